mxint_add_seq: RTL
==================

# mxint_add_seq

Sequential, parametrised MX block adder. Takes two MXINT blocks, each with one shared E8M0 scale and BLOCK_SIZE signed elements, and produces one normalised MXINT result block. The block processes LANES elements per cycle and handshakes with valid/ready on both sides. It sits in the MX ALU datapath as the multi-cycle successor of the combinational MXINT8 adder. Element width, block size and lane count are parameters, and the block adds a selectable rounding mode, saturation and NaN/overflow signalling.

## Interface
- ELEM_WIDTH, 8, element width W; two's complement, W-2 fraction bits
- BLOCK_SIZE, 32, elements per block
- SCALE_WIDTH, 8, shared scale width (E8M0, bias 127, 0xFF = NaN)
- LANES, 4, elements processed per cycle; BLOCK_SIZE % LANES must be 0; N = BLOCK_SIZE/LANES
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- i_valid  in  1  input block valid
- o_ready  out  1  block accepts input
- i_round  in  1  0 = truncate (floor), 1 = round to nearest, ties away from zero; sampled on accept
- i_scale_a, i_scale_b  in  SCALE_WIDTH  operand scales
- i_elements_a, i_elements_b  in  ELEM_WIDTH x [BLOCK_SIZE]  operand elements
- o_valid  out  1  result valid
- i_ready  in  1  downstream accepts result
- o_scale  out  SCALE_WIDTH  result scale
- o_elements  out  ELEM_WIDTH x [BLOCK_SIZE]  result elements
- o_overflow  out  1  result scale overflowed; o_scale forced to 0xFF

## Operation
- States: IDLE, SUM, NORM, DONE.
- IDLE: o_ready=1. When i_valid=1, the block captures scales, all elements and i_round, then goes to SUM with lane index 0.
- SUM takes N cycles. Per cycle it handles LANES elements:
  - Xm = max(Xa, Xb); d = |Xa - Xb|.
  - The element from the smaller-scale operand is arithmetic-right-shifted by min(d, W+1).
  - The (W+1)-bit sum is stored in the internal buffer.
  - A need_norm flag is set if any sum lies outside [-(2^(W-1)-1), 2^(W-1)-1].
- After lane index N-1, the block goes to NORM.
- NORM takes N cycles. Per cycle it handles LANES elements:
  - need_norm=0: output = sum, saturated to the symmetric range.
  - need_norm=1: output = sum >> 1, rounded per i_round, then saturated to ±(2^(W-1)-1).
- Scale rules:
  - o_scale = Xm + need_norm.
  - If Xm=254 and need_norm=1: o_scale=0xFF, o_overflow=1, all elements 0.
- NaN rule: if either input scale is 0xFF, then o_scale=0xFF, o_overflow=0, all elements 0. The SUM and NORM cycle counts are unchanged.
- DONE: o_valid=1. Outputs are held stable until i_ready=1, then the block returns to IDLE.
- No accept in the same cycle as the DONE→IDLE transition.
- -2^(W-1) on an input is treated as a normal value. It is never produced on an output.

## Timing
- Reset values, applied at the rising edge with rst=1:
  - state=IDLE, lane index 0
  - o_valid=0, o_scale=0, o_elements all 0, o_overflow=0
- o_ready is combinational: (state==IDLE) && !rst.
- Latency: o_valid rises exactly 2N rising edges after the accepting edge. With default parameters that is 16.
- Throughput: one block per 2N+2 cycles, with i_ready held at 1.
- rst in SUM, NORM or DONE: the in-flight block is discarded, the block returns to IDLE, and no o_valid pulse is produced.
- rst has priority over every handshake in the same cycle.
- Inputs are not required to be stable after the accepting edge.

## Test plan
- Equal scales: Xa=Xb=127, all a=16, b=32, i_round=0 -> o_scale=127, all elements 48, o_overflow=0, o_valid 16 edges after accept.
- Alignment: Xa=129, Xb=127, a=16, b=64 -> b shifted to 16; o_scale=129, elements 32. Also d=20, a=0, b=-5 -> elements -1 (floor).
- Normalisation and rounding: Xa=Xb=127, a[0]=127, b[0]=126, a[1]=-1, b[1]=-2, others 0:
  - i_round=0 -> o_scale=128, e0=126, e1=-2
  - i_round=1 -> e0=127, e1=-2
- Scale overflow and NaN:
  - Xa=Xb=254 with a[0]=b[0]=100 -> o_scale=0xFF, o_overflow=1, elements 0.
  - Xa=0xFF -> o_scale=0xFF, o_overflow=0.
- Backpressure: i_ready=0 for 5 cycles in DONE -> o_valid, o_scale and o_elements stable; o_ready=0. After i_ready=1, o_ready=1 on the next cycle.
- Reset mid-operation: rst for 1 cycle in SUM cycle 3 -> next cycle IDLE, o_valid=0, o_ready=1. A fresh block then completes correctly.

Source files
------------

// File: rtl/mxint_add_seq.sv
// Sequential MXINT block adder: aligns two scaled element blocks, sums LANES
// elements per cycle, then normalises/rounds/saturates into one result block.
module mxint_add_seq #(
  parameter int ELEM_WIDTH  = 8,
  parameter int BLOCK_SIZE  = 32,
  parameter int SCALE_WIDTH = 8,
  parameter int LANES       = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_valid,
  output logic                               o_ready,
  input  logic                               i_round,
  input  logic [SCALE_WIDTH-1:0]             i_scale_a,
  input  logic [SCALE_WIDTH-1:0]             i_scale_b,
  input  logic [BLOCK_SIZE*ELEM_WIDTH-1:0]   i_elements_a,
  input  logic [BLOCK_SIZE*ELEM_WIDTH-1:0]   i_elements_b,
  output logic                               o_valid,
  input  logic                               i_ready,
  output logic [SCALE_WIDTH-1:0]             o_scale,
  output logic [BLOCK_SIZE*ELEM_WIDTH-1:0]   o_elements,
  output logic                               o_overflow,
  output logic [1:0]                         o_dbg_state
);

  localparam int W  = ELEM_WIDTH;
  localparam int SW = SCALE_WIDTH;
  localparam int N  = BLOCK_SIZE / LANES;
  localparam int LW = (N > 1) ? $clog2(N) : 1;
  localparam logic signed [W:0] MAX_POS = {2'b00, {(W-1){1'b1}}};
  localparam logic signed [W:0] MAX_NEG = -MAX_POS;
  localparam logic [SW-1:0] SCALE_TOP = {{(SW-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {IDLE, SUM, NORM, DONE} state_e;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; o_valid holds with stable data until i_ready is seen.
  state_e                 state_q;
  logic [LW-1:0]          lane_q;
  logic [SW-1:0]          scale_a_q, scale_b_q;
  logic                   round_q;
  logic                   need_norm_q;
  logic [W-1:0]           ea_q [N][LANES];
  logic [W-1:0]           eb_q [N][LANES];
  logic signed [W:0]      sum_q [N][LANES];
  logic [W-1:0]           out_q [N][LANES];
  logic                   o_valid_q, o_overflow_q;
  logic [SW-1:0]          o_scale_q;

  logic [W-1:0]           in_a [N][LANES];
  logic [W-1:0]           in_b [N][LANES];

  for (genvar g = 0; g < BLOCK_SIZE; g++) begin : g_flat
    assign in_a[g / LANES][g % LANES]  = i_elements_a[g*W +: W];
    assign in_b[g / LANES][g % LANES]  = i_elements_b[g*W +: W];
    assign o_elements[g*W +: W]        = out_q[g / LANES][g % LANES];
  end

  logic                   a_big, nan, kill, ovf, any_out, last_lane;
  logic [SW-1:0]          xm, diff, shamt, scale_d;
  logic signed [W:0]      ext_a, ext_b, s_val, h_val, sat_val;
  logic signed [W:0]      lane_sum [LANES];
  logic [W-1:0]           lane_out [LANES];

  always_comb begin
    a_big   = scale_a_q >= scale_b_q;
    xm      = a_big ? scale_a_q : scale_b_q;
    diff    = a_big ? (scale_a_q - scale_b_q) : (scale_b_q - scale_a_q);
    shamt   = (diff > SW'(W + 1)) ? SW'(W + 1) : diff;
    nan     = (&scale_a_q) | (&scale_b_q);
    ovf     = !nan && (xm == SCALE_TOP) && need_norm_q;
    kill    = nan | ovf;
    scale_d = kill ? {SW{1'b1}} : xm + SW'(need_norm_q);
    last_lane = (lane_q == LW'(N - 1));
    any_out = 1'b0;
    ext_a   = '0;
    ext_b   = '0;
    s_val   = '0;
    h_val   = '0;
    sat_val = '0;
    for (int l = 0; l < LANES; l++) begin
      ext_a = {ea_q[lane_q][l][W-1], ea_q[lane_q][l]};
      ext_b = {eb_q[lane_q][l][W-1], eb_q[lane_q][l]};
      if (a_big) ext_b = ext_b >>> shamt;
      else       ext_a = ext_a >>> shamt;
      lane_sum[l] = ext_a + ext_b;
      if (lane_sum[l] > MAX_POS || lane_sum[l] < MAX_NEG) any_out = 1'b1;

      // Halving floors; round-to-nearest bumps only odd positive sums, since
      // for negative ties the floor already points away from zero.
      s_val = sum_q[lane_q][l];
      if (need_norm_q) begin
        h_val = s_val >>> 1;
        h_val = h_val + (W+1)'(round_q & s_val[0] & ~s_val[W]);
      end else begin
        h_val = s_val;
      end
      if (h_val > MAX_POS)      sat_val = MAX_POS;
      else if (h_val < MAX_NEG) sat_val = MAX_NEG;
      else                      sat_val = h_val;
      lane_out[l] = kill ? '0 : sat_val[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      lane_q       <= '0;
      need_norm_q  <= 1'b0;
      o_valid_q    <= 1'b0;
      o_scale_q    <= '0;
      o_overflow_q <= 1'b0;
      out_q        <= '{default: '0};
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            scale_a_q   <= i_scale_a;
            scale_b_q   <= i_scale_b;
            round_q     <= i_round;
            ea_q        <= in_a;
            eb_q        <= in_b;
            need_norm_q <= 1'b0;
            lane_q      <= '0;
            state_q     <= SUM;
          end
        end
        SUM: begin
          for (int l = 0; l < LANES; l++) sum_q[lane_q][l] <= lane_sum[l];
          need_norm_q <= need_norm_q | any_out;
          if (last_lane) begin
            lane_q  <= '0;
            state_q <= NORM;
          end else begin
            lane_q  <= lane_q + 1'b1;
          end
        end
        NORM: begin
          for (int l = 0; l < LANES; l++) out_q[lane_q][l] <= lane_out[l];
          if (last_lane) begin
            lane_q       <= '0;
            state_q      <= DONE;
            o_valid_q    <= 1'b1;
            o_scale_q    <= scale_d;
            o_overflow_q <= ovf;
          end else begin
            lane_q       <= lane_q + 1'b1;
          end
        end
        DONE: begin
          if (i_ready) begin
            o_valid_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ready     = (state_q == IDLE) && !rst;
  assign o_valid     = o_valid_q;
  assign o_scale     = o_scale_q;
  assign o_overflow  = o_overflow_q;
  assign o_dbg_state = state_q;

endmodule
